// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-array data memory with fixed-latency valid/ready responses
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  // Bits above the word index must be clear for an in-range address.
  localparam logic [31:0] HI_MASK = ~((32'd1 << (ADDR_W + 2)) - 32'd1);
  localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        pend_rdata_q;
  logic               pend_err_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic [31:0]        mem [0:(1 << ADDR_W) - 1];

  logic [ADDR_W-1:0]  idx;
  logic               addr_err;
  logic               accept;
  logic [31:0]        fresh_rdata;

  // Decode the request address and form the response it would produce now.
  always_comb begin
    idx         = req_addr[ADDR_W+1:2];
    addr_err    = (req_addr[1:0] != 2'b00) || ((req_addr & HI_MASK) != 32'd0);
    fresh_rdata = (addr_err || req_wr) ? 32'd0 : mem[idx];
  end

  // Next-state logic, handshake and response strobe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = rst && (state_q != WAIT);
    resp_valid = (state_q == RESP);
    accept     = req_valid && req_ready && !flush;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    // A flush drops whatever is outstanding; committed stores stay committed.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end
  end

  // State and latency counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the outcome of an accepted request until its response is due.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_rdata_q <= 32'd0;
      pend_err_q   <= 1'b0;
    end else if (accept) begin
      pend_rdata_q <= fresh_rdata;
      pend_err_q   <= addr_err;
    end
  end

  // Response registers change only when entering RESP; with a one-cycle latency
  // the data comes straight from the accepting edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (state_d == RESP) begin
      if (accept) begin
        rdata_q <= fresh_rdata;
        err_q   <= addr_err;
      end else begin
        rdata_q <= pend_rdata_q;
        err_q   <= pend_err_q;
      end
    end
  end

  // Stores commit on the accepting edge; error requests never write.
  always_ff @(posedge clk) begin
    if (accept && req_wr && !addr_err) begin
      mem[idx] <= req_wdata;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  rdy;
  logic [2:0]  rv;
  logic [2:0]  er;
  logic [31:0] rd [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[0]),
    .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_err(er[0]));

  dmem_responder #(.ADDR_W(10), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[1]),
    .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_err(er[1]));

  dmem_responder #(.ADDR_W(10), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[2]),
    .resp_valid(rv[2]), .resp_rdata(rd[2]), .resp_err(er[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int d);
    rst = 1'b0;
    tick();
    chk("rst_valid", {31'd0, rv[d]}, 32'd0);
    chk("rst_rdata", rd[d], 32'd0);
    chk("rst_err", {31'd0, er[d]}, 32'd0);
    chk("rst_ready", {31'd0, rdy[d]}, 32'd0);
    rst = 1'b1;
    #1;
  endtask

  // Issue one request on instance d and wait for its response pulse.
  task automatic req(input int d, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rdata,
                     output logic e, output int cyc);
    int w;
    w = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    while (!rdy[d] && w < 20) begin
      tick();
      w++;
    end
    tick();
    req_valid = 1'b0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      if (rv[d]) break;
      tick();
    end
    rdata = rd[d];
    e     = er[d];
    tick();
    chk("pulse_end", {31'd0, rv[d]}, 32'd0);
  endtask

  initial begin
    logic [31:0] rdata;
    logic        e;
    int          cyc;
    logic        seen;
    logic [31:0] exp_b2b [3];

    // LATENCY = 2: store/load round trip, errors, boundary word.
    do_reset(0);
    req(0, 1'b1, 32'h10, 32'hDEADBEEF, rdata, e, cyc);
    chk("st_lat", cyc, 32'd2);
    chk("st_rdata", rdata, 32'd0);
    chk("st_err", {31'd0, e}, 32'd0);
    req(0, 1'b0, 32'h10, 32'd0, rdata, e, cyc);
    chk("ld_lat", cyc, 32'd2);
    chk("ld_rdata", rdata, 32'hDEADBEEF);
    chk("ld_hold", rd[0], 32'hDEADBEEF);
    req(0, 1'b1, 32'h0, 32'hA5A5A5A5, rdata, e, cyc);
    req(0, 1'b1, 32'hFFC, 32'h600DF00D, rdata, e, cyc);
    req(0, 1'b0, 32'h13, 32'd0, rdata, e, cyc);
    chk("mis_err", {31'd0, e}, 32'd1);
    chk("mis_rdata", rdata, 32'd0);
    req(0, 1'b1, 32'h1000, 32'h12345678, rdata, e, cyc);
    chk("oor_err", {31'd0, e}, 32'd1);
    chk("oor_rdata", rdata, 32'd0);
    chk("oor_lat", cyc, 32'd2);
    req(0, 1'b0, 32'h0, 32'd0, rdata, e, cyc);
    chk("alias_rdata", rdata, 32'hA5A5A5A5);
    chk("alias_err", {31'd0, e}, 32'd0);
    req(0, 1'b0, 32'hFFC, 32'd0, rdata, e, cyc);
    chk("top_word", rdata, 32'h600DF00D);

    // LATENCY = 1: back-to-back loads with valid held high.
    do_reset(1);
    req(1, 1'b1, 32'h20, 32'h11110020, rdata, e, cyc);
    chk("l1_lat", cyc, 32'd1);
    req(1, 1'b1, 32'h24, 32'h22220024, rdata, e, cyc);
    req(1, 1'b1, 32'h28, 32'h33330028, rdata, e, cyc);
    exp_b2b[0] = 32'h11110020;
    exp_b2b[1] = 32'h22220024;
    exp_b2b[2] = 32'h33330028;
    req_valid = 1'b1;
    req_wr    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_addr = 32'h20 + 32'(4 * i);
      chk("b2b_ready", {31'd0, rdy[1]}, 32'd1);
      tick();
      chk("b2b_valid", {31'd0, rv[1]}, 32'd1);
      chk("b2b_rdata", rd[1], exp_b2b[i]);
    end
    req_valid = 1'b0;
    tick();
    chk("b2b_end", {31'd0, rv[1]}, 32'd0);

    // LATENCY = 3: flushes and reset in the middle of a wait.
    do_reset(2);
    req(2, 1'b1, 32'h40, 32'hCAFEF00D, rdata, e, cyc);
    chk("l3_lat", cyc, 32'd3);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 32'h40;
    tick();
    req_valid = 1'b0;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    chk("fl_valid", {31'd0, rv[2]}, 32'd0);
    chk("fl_ready", {31'd0, rdy[2]}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | rv[2];
    end
    chk("fl_noresp", {31'd0, seen}, 32'd0);

    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 32'h44;
    req_wdata = 32'h0BADC0DE;
    tick();
    req_valid = 1'b0;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    tick();
    req(2, 1'b0, 32'h44, 32'd0, rdata, e, cyc);
    chk("fl_store_kept", rdata, 32'h0BADC0DE);

    req(2, 1'b0, 32'h40, 32'd0, rdata, e, cyc);
    chk("pre_rst_rdata", rdata, 32'hCAFEF00D);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 32'h48;
    req_wdata = 32'h11112222;
    tick();
    req_valid = 1'b0;
    rst       = 1'b0;
    tick();
    chk("mid_rst_valid", {31'd0, rv[2]}, 32'd0);
    chk("mid_rst_rdata", rd[2], 32'd0);
    chk("mid_rst_err", {31'd0, er[2]}, 32'd0);
    chk("mid_rst_ready", {31'd0, rdy[2]}, 32'd0);
    rst  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | rv[2];
    end
    chk("mid_rst_noresp", {31'd0, seen}, 32'd0);
    req(2, 1'b0, 32'h48, 32'd0, rdata, e, cyc);
    chk("rst_store_kept", rdata, 32'h11112222);

    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 32'h40;
    flush     = 1'b1;
    tick();
    req_valid = 1'b0;
    flush     = 1'b0;
    chk("idle_fl_ready", {31'd0, rdy[2]}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | rv[2];
    end
    chk("idle_fl_noresp", {31'd0, seen}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
